// File: rtl/i2f32_pipe.sv
// i2f32_pipe: three-stage 32-bit signed/unsigned integer to IEEE-754 single converter
// with selectable rounding, inexact flag, valid token and global clock enable.
module i2f32_pipe #(
    parameter int FPWID = 32,
    parameter int EMSB  = 7,
    parameter int FMSB  = 22,
    parameter int BIAS  = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             vi,
    input  logic             op,
    input  logic [2:0]       rm,
    input  logic [FPWID-1:0] i,
    output logic             vo,
    output logic [FPWID-1:0] o,
    output logic             inexact
);
    localparam int GB = FPWID - FMSB - 3;
    localparam int EXP_TOP_I = BIAS + FPWID - 1;
    localparam logic [EMSB:0] EXP_TOP = EXP_TOP_I[EMSB:0];

    logic             w_sgn;
    logic [FPWID-1:0] w_a;
    logic             r1_v, r1_sgn, r1_iz;
    logic [2:0]       r1_rm;
    logic [FPWID-1:0] r1_a;

    assign w_sgn = op & i[FPWID-1];
    assign w_a   = w_sgn ? -i : i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_v   <= 1'b0;
            r1_sgn <= 1'b0;
            r1_iz  <= 1'b0;
            r1_rm  <= '0;
            r1_a   <= '0;
        end else if (ce) begin
            r1_v   <= vi;
            r1_sgn <= w_sgn;
            r1_iz  <= (w_a == '0);
            r1_rm  <= rm;
            r1_a   <= w_a;
        end
    end

    // Log shifter: each step normalizes by a power of two and records that lz bit.
    logic [4:0]       w_lz;
    logic [FPWID-1:0] w_t4, w_t3, w_t2, w_t1;
    logic [FPWID-2:0] w_n;

    assign w_lz[4] = ~|r1_a[FPWID-1:FPWID-16];
    assign w_t4    = w_lz[4] ? r1_a << 16 : r1_a;
    assign w_lz[3] = ~|w_t4[FPWID-1:FPWID-8];
    assign w_t3    = w_lz[3] ? w_t4 << 8 : w_t4;
    assign w_lz[2] = ~|w_t3[FPWID-1:FPWID-4];
    assign w_t2    = w_lz[2] ? w_t3 << 4 : w_t3;
    assign w_lz[1] = ~|w_t2[FPWID-1:FPWID-2];
    assign w_t1    = w_lz[1] ? w_t2 << 2 : w_t2;
    assign w_lz[0] = ~w_t1[FPWID-1];
    assign w_n     = w_lz[0] ? {w_t1[FPWID-3:0], 1'b0} : w_t1[FPWID-2:0];

    logic             r2_v, r2_sgn, r2_iz;
    logic [2:0]       r2_rm;
    logic [EMSB:0]    r2_ex;
    logic [FPWID-2:0] r2_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_v   <= 1'b0;
            r2_sgn <= 1'b0;
            r2_iz  <= 1'b0;
            r2_rm  <= '0;
            r2_ex  <= '0;
            r2_n   <= '0;
        end else if (ce) begin
            r2_v   <= r1_v;
            r2_sgn <= r1_sgn;
            r2_iz  <= r1_iz;
            r2_rm  <= r1_rm;
            r2_ex  <= EXP_TOP - {{(EMSB-4){1'b0}}, w_lz};
            r2_n   <= w_n;
        end
    end

    // The hidden bit is implicit; a carry out of the fraction means the
    // mantissa rolled over to 2.0, so the fraction is already zero.
    logic          w_g, w_s, w_lsb, w_up, w_fc;
    logic [FMSB:0] w_frac;
    logic [EMSB:0] w_exp;

    assign w_g   = r2_n[GB];
    assign w_s   = |r2_n[GB-1:0];
    assign w_lsb = r2_n[GB+1];

    always_comb begin
        w_up = (r2_rm == 3'd1) ? 1'b0 :
               (r2_rm == 3'd2) ? (r2_sgn & (w_g | w_s)) :
               (r2_rm == 3'd3) ? (~r2_sgn & (w_g | w_s)) :
               (r2_rm == 3'd4) ? w_g :
                                 (w_g & (w_s | w_lsb));
    end

    assign {w_fc, w_frac} = {1'b0, r2_n[FPWID-2:GB+1]} + {{(FMSB+1){1'b0}}, w_up};
    assign w_exp = r2_ex + {{EMSB{1'b0}}, w_fc};

    logic             r_vo, r_inexact;
    logic [FPWID-1:0] r_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vo      <= 1'b0;
            r_o       <= '0;
            r_inexact <= 1'b0;
        end else if (ce) begin
            r_vo      <= r2_v;
            r_o       <= r2_iz ? '0 : {r2_sgn, w_exp, w_frac};
            r_inexact <= ~r2_iz & (w_g | w_s);
        end
    end

    assign vo      = r_vo;
    assign o       = r_o;
    assign inexact = r_inexact;
endmodule

// File: tb/tb_i2f32_pipe.sv
// tb_i2f32_pipe: directed vectors with hand-computed results for i2f32_pipe,
// covering rounding modes, extremes, streaming with stalls and mid-flight reset.
module tb_i2f32_pipe;
    logic        clk = 1'b0;
    logic        rst, ce, vi, op;
    logic [2:0]  rm;
    logic [31:0] i;
    logic        vo, inexact;
    logic [31:0] o;

    int n_checks = 0;
    int n_errors = 0;

    i2f32_pipe dut (
        .clk(clk), .rst(rst), .ce(ce), .vi(vi), .op(op), .rm(rm), .i(i),
        .vo(vo), .o(o), .inexact(inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp_v);
        end
    endtask

    task automatic conv(input string tag, input logic iop, input logic [2:0] irm,
                        input logic [31:0] iv, input logic [31:0] eo, input logic ex);
        @(negedge clk);
        vi = 1'b1; op = iop; rm = irm; i = iv;
        @(negedge clk);
        vi = 1'b0;
        @(negedge clk);
        check({tag, "_early"}, {31'b0, vo}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_vo"}, {31'b0, vo}, 32'd1);
        check({tag, "_o"}, o, eo);
        check({tag, "_inx"}, {31'b0, inexact}, {31'b0, ex});
    endtask

    logic        s_op[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  s_rm[8] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd3, 3'd2, 3'd0};
    logic [31:0] s_i[8]  = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                             32'h80000000, 32'h01000001, 32'hFEFFFFFF, 32'h01000003};
    logic [31:0] s_e[8]  = '{32'h3F800000, 32'hBF800000, 32'h4F7FFFFF, 32'h0,
                             32'hCF000000, 32'h4B800001, 32'hCB800001, 32'h4B800002};
    logic        s_x[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    logic        pv[3];
    logic [31:0] po[3];
    logic        px[3];

    initial begin
        int k;
        logic prev_ce;
        logic [31:0] prev_o;
        rst = 1'b1; ce = 1'b1; vi = 1'b0; op = 1'b0; rm = 3'd0; i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vo", {31'b0, vo}, 32'd0);
        check("rst_o", o, 32'd0);
        check("rst_inx", {31'b0, inexact}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        conv("one",        1'b1, 3'd0, 32'h00000001, 32'h3F800000, 1'b0);
        conv("neg_one",    1'b1, 3'd0, 32'hFFFFFFFF, 32'hBF800000, 1'b0);
        conv("zero",       1'b1, 3'd0, 32'h00000000, 32'h00000000, 1'b0);
        conv("zero_rup",   1'b1, 3'd3, 32'h00000000, 32'h00000000, 1'b0);
        conv("smin",       1'b1, 3'd0, 32'h80000000, 32'hCF000000, 1'b0);
        conv("u80",        1'b0, 3'd0, 32'h80000000, 32'h4F000000, 1'b0);
        conv("umax_rne",   1'b0, 3'd0, 32'hFFFFFFFF, 32'h4F800000, 1'b1);
        conv("umax_rtz",   1'b0, 3'd1, 32'hFFFFFFFF, 32'h4F7FFFFF, 1'b1);
        conv("smax",       1'b1, 3'd0, 32'h7FFFFFFF, 32'h4F000000, 1'b1);
        conv("neg3",       1'b1, 3'd0, 32'hFFFFFFFD, 32'hC0400000, 1'b0);
        conv("exact24",    1'b0, 3'd0, 32'h00FFFFFF, 32'h4B7FFFFF, 1'b0);
        conv("tie_dn",     1'b0, 3'd0, 32'h01000001, 32'h4B800000, 1'b1);
        conv("tie_up",     1'b0, 3'd0, 32'h01000003, 32'h4B800002, 1'b1);
        conv("rtz",        1'b0, 3'd1, 32'h01000001, 32'h4B800000, 1'b1);
        conv("rdn_pos",    1'b0, 3'd2, 32'h01000001, 32'h4B800000, 1'b1);
        conv("rup",        1'b0, 3'd3, 32'h01000001, 32'h4B800001, 1'b1);
        conv("rmm",        1'b0, 3'd4, 32'h01000001, 32'h4B800001, 1'b1);
        conv("rm5",        1'b0, 3'd5, 32'h01000001, 32'h4B800000, 1'b1);
        conv("neg_rdn",    1'b1, 3'd2, 32'hFEFFFFFF, 32'hCB800001, 1'b1);
        conv("neg_rup",    1'b1, 3'd3, 32'hFEFFFFFF, 32'hCB800000, 1'b1);
        conv("neg_rmm",    1'b1, 3'd4, 32'hFEFFFFFF, 32'hCB800001, 1'b1);

        repeat (4) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            pv[j] = 1'b0; po[j] = 32'd0; px[j] = 1'b0;
        end
        k = 0;
        prev_ce = 1'b1;
        prev_o = 32'd0;
        for (int step = 0; step < 16; step++) begin
            @(negedge clk);
            check("s_vo", {31'b0, vo}, {31'b0, pv[2]});
            if (pv[2]) begin
                check("s_o", o, po[2]);
                check("s_inx", {31'b0, inexact}, {31'b0, px[2]});
            end
            if (!prev_ce) check("s_hold", o, prev_o);
            prev_o = o;
            ce = !(step == 5 || step == 6);
            vi = (k < 8) && (k != 3);
            if (k < 8) begin
                op = s_op[k]; rm = s_rm[k]; i = s_i[k];
            end
            @(posedge clk);
            if (ce) begin
                pv[2] = pv[1]; po[2] = po[1]; px[2] = px[1];
                pv[1] = pv[0]; po[1] = po[0]; px[1] = px[0];
                pv[0] = vi;
                po[0] = s_e[k < 8 ? k : 0];
                px[0] = s_x[k < 8 ? k : 0];
                if (k < 8) k++;
            end
            prev_ce = ce;
        end
        ce = 1'b1;

        @(negedge clk);
        vi = 1'b1; op = 1'b0; rm = 3'd0; i = 32'd5;
        @(negedge clk);
        i = 32'd6;
        @(negedge clk);
        i = 32'd7;
        @(negedge clk);
        check("pre_rst_vo", {31'b0, vo}, 32'd1);
        check("pre_rst_o", o, 32'h40A00000);
        vi = 1'b0; rst = 1'b1; ce = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_vo", {31'b0, vo}, 32'd0);
        check("mid_rst_o", o, 32'd0);
        check("mid_rst_inx", {31'b0, inexact}, 32'd0);
        @(negedge clk);
        rst = 1'b0; ce = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_vo", {31'b0, vo}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
